// File: rtl/bias_buffer.sv
// bias_buffer: DEPTH x DATA_W bias word store. Words are loaded sequentially
// through a wrapping load pointer and read back as bursts on a valid/ready
// output stream. The output register is the read-data register, so read
// latency is one cycle and the output is held stable while stalled.
// Optional feature: define BIAS_BUF_ZERO_ON_RESET_EN to add a clear sequencer
// that zeroes every entry after reset before the buffer becomes available.
module bias_buffer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid_i,
   input  logic [DATA_W-1:0] load_data_i,
   output logic              load_ready_o,
   output logic              load_done_o,
   input  logic              rd_start_i,
   input  logic [ADDR_W-1:0] rd_base_i,
   input  logic [ADDR_W:0]   rd_len_i,
   output logic              rd_busy_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_last_o
);

   localparam int unsigned LEN_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_e;

`ifdef BIAS_BUF_ZERO_ON_RESET_EN
   localparam state_e RESET_STATE = CLEAR;
`else
   localparam state_e RESET_STATE = IDLE;
`endif

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [ADDR_W-1:0]   load_ptr_q, load_ptr_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                load_done_q, load_done_d;
   logic                load_ready_q, load_ready_d;
   logic                rd_busy_q, rd_busy_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [DATA_W-1:0]   out_data_q;

   logic                wr_en_c;
   logic [ADDR_W-1:0]   wr_addr_c;
   logic [DATA_W-1:0]   wr_data_c;
   logic                rd_en_c;
   logic [ADDR_W-1:0]   rd_addr_c;

`ifdef BIAS_BUF_ZERO_ON_RESET_EN
   logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
`endif

   // Next-state, memory port control and output-register next values
   always_comb begin
      state_d     = state_q;
      load_ptr_d  = load_ptr_q;
      base_d      = base_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      load_done_d = 1'b0;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      wr_en_c     = 1'b0;
      wr_addr_c   = load_ptr_q;
      wr_data_c   = load_data_i;
      rd_en_c     = 1'b0;
      rd_addr_c   = base_q + cnt_q[ADDR_W-1:0];
`ifdef BIAS_BUF_ZERO_ON_RESET_EN
      clr_ptr_d   = clr_ptr_q;
`endif

      // An accepted word empties the output register unless refilled below
      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      unique case (state_q)
`ifdef BIAS_BUF_ZERO_ON_RESET_EN
         CLEAR: begin
            wr_en_c   = 1'b1;
            wr_addr_c = clr_ptr_q;
            wr_data_c = '0;
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = IDLE;
            end
         end
`endif
         IDLE: begin
            // Loads only land in IDLE, so they always precede the next burst's reads
            if (load_valid_i) begin
               wr_en_c     = 1'b1;
               load_ptr_d  = load_ptr_q + ADDR_W'(1);
               load_done_d = (load_ptr_q == ADDR_W'(DEPTH - 1));
            end
            if (rd_start_i && (rd_len_i != '0)) begin
               state_d = READ;
               base_d  = rd_base_i;
               len_d   = rd_len_i;
               cnt_d   = '0;
            end
         end
         READ: begin
            if (!out_valid_q || out_ready_i) begin
               rd_en_c     = 1'b1;
               out_valid_d = 1'b1;
               out_last_d  = (cnt_q == (len_q - LEN_W'(1)));
               cnt_d       = cnt_q + LEN_W'(1);
               if (out_last_d) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (out_valid_q && out_ready_i && out_last_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      load_ready_d = (state_d == IDLE);
      rd_busy_d    = (state_d != IDLE);
   end

   // State, pointers, burst counters and control outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RESET_STATE;
         load_ptr_q   <= '0;
         base_q       <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         load_done_q  <= 1'b0;
         load_ready_q <= (RESET_STATE == IDLE);
         rd_busy_q    <= (RESET_STATE != IDLE);
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_ptr_q   <= load_ptr_d;
         base_q       <= base_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         load_done_q  <= load_done_d;
         load_ready_q <= load_ready_d;
         rd_busy_q    <= rd_busy_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
      end
   end

`ifdef BIAS_BUF_ZERO_ON_RESET_EN
   // Clear sequencer address
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_ptr_q <= '0;
      end else begin
         clr_ptr_q <= clr_ptr_d;
      end
   end
`endif

   // Storage array write port (contents are not reset)
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem_q[wr_addr_c] <= wr_data_c;
      end
   end

   // Synchronous read port feeding the output data register
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q <= '0;
      end else if (rd_en_c) begin
         out_data_q <= mem_q[rd_addr_c];
      end
   end

   assign load_ready_o = load_ready_q;
   assign load_done_o  = load_done_q;
   assign rd_busy_o    = rd_busy_q;
   assign out_valid_o  = out_valid_q;
   assign out_last_o   = out_last_q;
   assign out_data_o   = out_data_q;

endmodule

// File: tb/tb_bias_buffer.sv
// tb_bias_buffer: directed, table-driven bench for bias_buffer (DEPTH=16, DATA_W=32).
// Builds with or without BIAS_BUF_ZERO_ON_RESET_EN.
module tb_bias_buffer;

`ifdef BIAS_BUF_ZERO_ON_RESET_EN
   localparam int  CLR_N    = 16;
   localparam bit  CLR_BUSY = 1'b1;
`else
   localparam int  CLR_N    = 0;
   localparam bit  CLR_BUSY = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_ready;
   logic        load_done;
   logic        rd_start;
   logic [3:0]  rd_base;
   logic [4:0]  rd_len;
   logic        rd_busy;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] exp_mem [16];
   logic [3:0]  ld_ptr;

   typedef struct {
      logic [3:0]  base;
      logic [4:0]  len;
      logic [15:0] pat;
      int          exp_n;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
   } vec_t;

   vec_t vecs [6];

   bias_buffer #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid_i(load_valid),
      .load_data_i (load_data),
      .load_ready_o(load_ready),
      .load_done_o (load_done),
      .rd_start_i  (rd_start),
      .rd_base_i   (rd_base),
      .rd_len_i    (rd_len),
      .rd_busy_o   (rd_busy),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_last_o  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Count cycles until rd_busy drops (bounded)
   task automatic wait_clear(output int n);
      n = 0;
      while (rd_busy && n < 64) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Run one burst; optionally present a load in the same cycle as rd_start
   task automatic run_burst(input logic [3:0] base, input logic [4:0] len, input logic [15:0] pat,
                            input bit ld, input logic [31:0] ld_val,
                            output int got, output logic [31:0] first_w,
                            output logic [31:0] last_w, output int span);
      int          k;
      int          t_first;
      int          n_exp;
      bit          held;
      logic [31:0] hd;
      logic [31:0] ew;
      n_exp = int'(len);
      got = 0; k = 0; t_first = 0; span = 0;
      held = 1'b0; hd = '0; first_w = '0; last_w = '0;
      rd_base  = base;
      rd_len   = len;
      rd_start = 1'b1;
      if (ld) begin
         load_valid = 1'b1;
         load_data  = ld_val;
         exp_mem[ld_ptr] = ld_val;
         ld_ptr++;
      end
      out_ready = pat[0];
      if (n_exp == 0) begin
         @(negedge clk);
         rd_start   = 1'b0;
         load_valid = 1'b0;
      end
      while (got < n_exp && k < 200) begin
         if (k > 0) begin
            if (held) begin
               check("hold_valid", 32'(out_valid), 32'd1);
               check("hold_data", out_data, hd);
            end
            out_ready = pat[k % 16];
         end
         if (out_valid && out_ready) begin
            ew = exp_mem[(int'(base) + got) % 16];
            check("burst_data", out_data, ew);
            check("burst_last", 32'(out_last), 32'(got == n_exp - 1));
            if (got == 0) begin
               first_w = out_data;
               t_first = k;
            end
            last_w = out_data;
            span   = k - t_first;
            got++;
         end
         held = out_valid && !out_ready;
         hd   = out_data;
         @(negedge clk);
         rd_start   = 1'b0;
         load_valid = 1'b0;
         k++;
      end
      check("burst_count", 32'(got), 32'(n_exp));
      check("post_valid", 32'(out_valid), 32'd0);
      check("post_busy", 32'(rd_busy), 32'd0);
   endtask

   initial begin
      int          got;
      int          span;
      int          ncl;
      int          ndone;
      logic [31:0] fw;
      logic [31:0] lw;

      vecs[0] = '{base: 4'd0,  len: 5'd16, pat: 16'hFFFF, exp_n: 16, exp_first: 32'h100, exp_last: 32'h10F};
      vecs[1] = '{base: 4'd14, len: 5'd4,  pat: 16'hFFFF, exp_n: 4,  exp_first: 32'h10E, exp_last: 32'h101};
      vecs[2] = '{base: 4'd5,  len: 5'd3,  pat: 16'h9249, exp_n: 3,  exp_first: 32'h105, exp_last: 32'h107};
      vecs[3] = '{base: 4'd7,  len: 5'd0,  pat: 16'hFFFF, exp_n: 0,  exp_first: 32'h0,   exp_last: 32'h0};
      vecs[4] = '{base: 4'd15, len: 5'd1,  pat: 16'hFFFF, exp_n: 1,  exp_first: 32'h10F, exp_last: 32'h10F};
      vecs[5] = '{base: 4'd3,  len: 5'd5,  pat: 16'hAAAA, exp_n: 5,  exp_first: 32'h103, exp_last: 32'h107};

      for (int i = 0; i < 16; i++) exp_mem[i] = '0;
      ld_ptr     = '0;
      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      rd_start   = 1'b0;
      rd_base    = '0;
      rd_len     = '0;
      out_ready  = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_load_ready", 32'(load_ready), 32'(!CLR_BUSY));
      check("rst_rd_busy", 32'(rd_busy), 32'(CLR_BUSY));
      rst = 1'b0;
      wait_clear(ncl);
      check("clear_cycles", 32'(ncl), 32'(CLR_N));

`ifdef BIAS_BUF_ZERO_ON_RESET_EN
      run_burst(4'd0, 5'd16, 16'hFFFF, 1'b0, 32'h0, got, fw, lw, span);
      check("zero_count", 32'(got), 32'd16);
`endif

      // Load 0x100+i into all entries; load_done pulses once after entry 15
      ndone = 0;
      for (int i = 0; i < 16; i++) begin
         check("load_ready", 32'(load_ready), 32'd1);
         if (load_done) ndone++;
         load_valid = 1'b1;
         load_data  = 32'h100 + 32'(i);
         exp_mem[ld_ptr] = load_data;
         ld_ptr++;
         @(negedge clk);
      end
      load_valid = 1'b0;
      check("load_done_pulse", 32'(load_done), 32'd1);
      if (load_done) ndone++;
      @(negedge clk);
      check("load_done_clear", 32'(load_done), 32'd0);
      check("load_done_count", 32'(ndone), 32'd1);

      for (int v = 0; v < 6; v++) begin
         run_burst(vecs[v].base, vecs[v].len, vecs[v].pat, 1'b0, 32'h0, got, fw, lw, span);
         check("vec_count", 32'(got), 32'(vecs[v].exp_n));
         if (vecs[v].exp_n > 0) begin
            check("vec_first", fw, vecs[v].exp_first);
            check("vec_last", lw, vecs[v].exp_last);
            if (vecs[v].pat == 16'hFFFF) check("vec_span", 32'(span), 32'(vecs[v].exp_n - 1));
         end
      end

      // Load accepted together with rd_start lands before the first read
      run_burst(4'd0, 5'd1, 16'hFFFF, 1'b1, 32'hDEADBEEF, got, fw, lw, span);
      check("same_cycle_load", fw, 32'hDEADBEEF);

      // Reset mid-burst after two words accepted
      rd_base   = 4'd0;
      rd_len    = 5'd16;
      rd_start  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_valid", 32'(out_valid), 32'd1);
      check("mid_data", out_data, exp_mem[2]);
      rst = 1'b1;
      @(negedge clk);
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_busy", 32'(rd_busy), 32'(CLR_BUSY));
      check("abort_load_ready", 32'(load_ready), 32'(!CLR_BUSY));
      check("abort_data", out_data, 32'd0);
      rst = 1'b0;
      wait_clear(ncl);
      check("abort_clear_cycles", 32'(ncl), 32'(CLR_N));
      for (int i = 0; i < 3; i++) begin
         check("abort_no_output", 32'(out_valid), 32'd0);
         @(negedge clk);
      end
`ifdef BIAS_BUF_ZERO_ON_RESET_EN
      for (int i = 0; i < 16; i++) exp_mem[i] = '0;
`endif

      // Load pointer restarts at entry 0 after reset
      ld_ptr = '0;
      check("post_rst_ready", 32'(load_ready), 32'd1);
      load_valid = 1'b1;
      load_data  = 32'h55AA;
      exp_mem[ld_ptr] = load_data;
      ld_ptr++;
      @(negedge clk);
      load_valid = 1'b0;
      run_burst(4'd0, 5'd1, 16'hFFFF, 1'b0, 32'h0, got, fw, lw, span);
      check("post_rst_word", fw, 32'h55AA);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
